// File: rtl/viterbi_frame_ctrl_if.sv
// viterbi_frame_ctrl_if: symbol input stream and decoded-bit output stream of viterbi_frame_ctrl
//   in_valid  : source has a code symbol on in_cx
//   in_cx     : 2-bit received code symbol
//   in_ready  : controller takes in_cx this cycle
//   out_valid : out_bit carries a decoded data bit (no backpressure)
//   out_bit   : decoded bit
//   out_last  : with out_valid, final bit of the frame
//   modport master : symbol source / bit consumer side
//   modport slave  : controller side
interface viterbi_frame_ctrl_if;
    logic       in_valid;
    logic [1:0] in_cx;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    modport master (output in_valid, in_cx, input in_ready, out_valid, out_bit, out_last);
    modport slave  (input in_valid, in_cx, output in_ready, out_valid, out_bit, out_last);
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl: frame sequencer around a free-running viterbi_decoder
//   clk, reset : clock and synchronous active-high reset
//   start      : frame request, sampled in IDLE only
//   bus        : slave side of viterbi_frame_ctrl_if (symbol in, decoded bits out)
//   dec_cx     : symbol to the decoder (00 outside accepted RUN cycles)
//   dec_reset  : decoder reset (reset, CLEAR, ERR)
//   dec_d      : decoder decision, SPD_LAT cycles behind its symbol
//   busy       : frame in progress
//   done       : one-cycle pulse at frame completion
//   err        : one-cycle pulse on input underrun
//   Optional macro VITCTRL_STATS_EN adds saturating counters frames_done[15:0]
//   and underruns[7:0], cleared by reset.
module viterbi_frame_ctrl #(
    parameter int FRAME_LEN = 64,
    parameter int TAIL_LEN  = 2,
    parameter int SPD_LAT   = 15,
    parameter int CLR_CYC   = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    viterbi_frame_ctrl_if.slave  bus,
    output logic [1:0]           dec_cx,
    output logic                 dec_reset,
    input  logic                 dec_d,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef VITCTRL_STATS_EN
    ,
    output logic [15:0]          frames_done,
    output logic [7:0]           underruns
`endif
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, TAIL, DRAIN, DONE, ERR} state_e;
    localparam logic [CNT_W-1:0] T_RUN_END  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] T_TAIL_END = CNT_W'(FRAME_LEN + TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] T_END      = CNT_W'(FRAME_LEN + SPD_LAT);
    localparam logic [CNT_W-1:0] T_OUT_LO   = CNT_W'(SPD_LAT);
    localparam logic [CNT_W-1:0] T_OUT_HI   = CNT_W'(FRAME_LEN + SPD_LAT - 1);
    localparam logic [CNT_W-1:0] C_END      = CNT_W'(CLR_CYC - 1);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] t_q, t_d, clr_q, clr_d;
    logic             out_valid_q, out_valid_d, out_bit_q, out_last_q, out_last_d;
    always_comb begin
        state_d = state_q;
        t_d     = '0;
        clr_d   = '0;
        case (state_q)
            IDLE:  state_d = start ? CLEAR : IDLE;
            CLEAR: begin
                clr_d   = clr_q == C_END ? '0 : clr_q + 1'b1;
                state_d = clr_q == C_END ? RUN : CLEAR;
            end
            // The decoder cannot stall, so a missing symbol aborts the frame.
            RUN: begin
                t_d     = bus.in_valid ? t_q + 1'b1 : '0;
                state_d = !bus.in_valid ? ERR : (t_q == T_RUN_END ? TAIL : RUN);
            end
            TAIL: begin
                t_d     = t_q + 1'b1;
                state_d = t_q == T_TAIL_END ? DRAIN : TAIL;
            end
            DRAIN: begin
                t_d     = t_q == T_END ? '0 : t_q + 1'b1;
                state_d = t_q == T_END ? DONE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
        // Gating on the next state drops a decision that would land in ERR.
        out_valid_d = (state_d == RUN || state_d == TAIL || state_d == DRAIN) &&
                      t_q >= T_OUT_LO && t_q <= T_OUT_HI;
        out_last_d  = out_valid_d && t_q == T_OUT_HI;
        bus.in_ready  = state_q == RUN;
        dec_cx        = (state_q == RUN && bus.in_valid) ? bus.in_cx : 2'b00;
        dec_reset     = reset || state_q == CLEAR || state_q == ERR;
        busy          = state_q != IDLE;
        done          = state_q == DONE;
        err           = state_q == ERR;
        bus.out_valid = out_valid_q;
        bus.out_bit   = out_bit_q;
        bus.out_last  = out_last_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            t_q         <= '0;
            clr_q       <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            clr_q       <= clr_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= dec_d;
            out_last_q  <= out_last_d;
        end
    end
`ifdef VITCTRL_STATS_EN
    logic [15:0] frames_done_q, frames_done_d;
    logic [7:0]  underruns_q, underruns_d;
    always_comb begin
        frames_done_d = frames_done_q + 16'(done && frames_done_q != '1);
        underruns_d   = underruns_q + 8'(err && underruns_q != '1);
        frames_done   = frames_done_q;
        underruns     = underruns_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_done_q <= '0;
            underruns_q   <= '0;
        end else begin
            frames_done_q <= frames_done_d;
            underruns_q   <= underruns_d;
        end
    end
`endif
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb_viterbi_frame_ctrl: bench for viterbi_frame_ctrl with an error-free decoder stub
//   The stub inverts the K=3 (111,101) code from the 101 output alone, so flips of the
//   111 output bit leave decoded data unchanged, and it delays decisions by SPD cycles.
module tb_viterbi_frame_ctrl;
    localparam int FL = 8, TL = 2, SPD = 15, CLR = 2;
    localparam int OUT0 = CLR + SPD + 1;
    localparam int DONE_CYC = CLR + FL + SPD + 1;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic dec_d, dec_reset, busy, done, err;
    logic [1:0] dec_cx;
    logic [FL-1:0] rd, rf;
    int checks = 0, errors = 0;
    viterbi_frame_ctrl_if bus ();
`ifdef VITCTRL_STATS_EN
    logic [15:0] frames_done;
    logic [7:0] underruns;
    int m_frames = 0, m_under = 0;
`endif
    viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(TL), .SPD_LAT(SPD), .CLR_CYC(CLR), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus.slave), .dec_cx(dec_cx),
        .dec_reset(dec_reset), .dec_d(dec_d), .busy(busy), .done(done), .err(err)
`ifdef VITCTRL_STATS_EN
        , .frames_done(frames_done), .underruns(underruns)
`endif
    );
    always #5 clk = ~clk;

    logic s1, s2;
    logic [SPD-1:0] dl;
    always @(posedge clk)
        if (dec_reset) begin
            s1 <= 1'b0; s2 <= 1'b0; dl <= '0;
        end else begin
            s1 <= dec_cx[0] ^ s2; s2 <= s1; dl <= {dl[SPD-2:0], dec_cx[0] ^ s2};
        end
    assign dec_d = dl[SPD-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // d and flip are MSB-first: bit for symbol k is at index FL-1-k.
    task automatic frame(input logic [FL-1:0] d, input logic [FL-1:0] flip, input int under_k,
                         input int rst_cyc, input bit pulses, input bit hold);
        logic [1:0] sym [FL];
        bit b [FL+2];
        int last, done_at, j, k;
        bit ended, errc, runc, ov;
        b[0] = 1'b0; b[1] = 1'b0;
        for (int i = 0; i < FL; i++) b[i+2] = d[FL-1-i];
        for (int i = 0; i < FL; i++) sym[i] = {b[i+2] ^ b[i+1] ^ b[i] ^ flip[FL-1-i], b[i+2] ^ b[i]};
        last = under_k >= 0 ? CLR + under_k + 1 : (rst_cyc >= 0 ? rst_cyc + 12 : DONE_CYC);
        done_at = -1;
        start = 1'b1;
        @(negedge clk);
        chk("busy@idle", 32'(busy), 32'(0));
        @(posedge clk); #1;
        for (int c = 0; c <= last; c++) begin
            k = c - CLR;
            j = c - OUT0;
            ended = (under_k >= 0 && c > CLR + under_k + 1) || (rst_cyc >= 0 && c > rst_cyc);
            errc = under_k >= 0 && c == CLR + under_k + 1;
            runc = !ended && !errc && k >= 0 && k < FL;
            ov = !ended && !errc && j >= 0 && j < FL;
            reset = c == rst_cyc;
            start = (pulses && (c == CLR + 3 || c == CLR + FL + 5)) || (hold && c >= DONE_CYC - 1);
            bus.in_valid = runc ? k != under_k : 1'($urandom);
            bus.in_cx = (runc && k != under_k) ? sym[k] : 2'($urandom);
            @(negedge clk);
            chk($sformatf("busy@%0d", c), 32'(busy), 32'(!ended));
            chk($sformatf("in_ready@%0d", c), 32'(bus.in_ready), 32'(runc));
            chk($sformatf("dec_cx@%0d", c), 32'(dec_cx), 32'((runc && k != under_k) ? sym[k] : 2'b00));
            chk($sformatf("dec_reset@%0d", c), 32'(dec_reset), 32'((!ended && (c < CLR || errc)) || c == rst_cyc));
            chk($sformatf("out_valid@%0d", c), 32'(bus.out_valid), 32'(ov));
            if (ov) chk($sformatf("out_bit%0d", j), 32'(bus.out_bit), 32'(b[j+2]));
            chk($sformatf("out_last@%0d", c), 32'(bus.out_last), 32'(ov && j == FL - 1));
            chk($sformatf("done@%0d", c), 32'(done), 32'(!ended && c == DONE_CYC));
            chk($sformatf("err@%0d", c), 32'(err), 32'(errc));
            if (done === 1'b1 && done_at < 0) done_at = c;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        if (under_k < 0 && rst_cyc < 0) chk("frame_cycles", 32'(done_at), 32'(DONE_CYC));
`ifdef VITCTRL_STATS_EN
        if (rst_cyc >= 0) begin m_frames = 0; m_under = 0; end
        else if (under_k >= 0) m_under++;
        else m_frames++;
`endif
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_cx = 2'b00;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_dec_reset", 32'(dec_reset), 32'(1));
            chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
            chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_dec_cx", 32'(dec_cx), 32'(0));
            chk("rst_done_err", 32'({done, err}), 32'(0));
`ifdef VITCTRL_STATS_EN
            chk("rst_stats", 32'({frames_done, underruns}), 32'(0));
`endif
        end
        @(posedge clk); #1;
        reset = 1'b0;
        frame(8'b10110010, 8'b00000000, -1, -1, 1'b0, 1'b0);
        frame(8'b10110010, 8'b00010000, -1, -1, 1'b0, 1'b0);
        frame(8'b10110010, 8'b00000000, 5, -1, 1'b0, 1'b0);
`ifdef VITCTRL_STATS_EN
        chk("underruns", 32'(underruns), 32'(m_under));
`endif
        rd = FL'($urandom);
        frame(rd, 8'b00000000, -1, -1, 1'b1, 1'b1);
        rd = FL'($urandom);
        frame(rd, 8'b00000000, -1, -1, 1'b0, 1'b0);
`ifdef VITCTRL_STATS_EN
        chk("frames_done", 32'(frames_done), 32'(m_frames));
`endif
        rd = FL'($urandom);
        frame(rd, 8'b00000000, -1, CLR + 12, 1'b0, 1'b0);
        frame(8'b10110010, 8'b00000000, -1, -1, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            rd = FL'($urandom);
            rf = FL'($urandom);
            frame(rd, rf, ($urandom_range(3) == 0) ? int'($urandom_range(FL - 1)) : -1, -1, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("final_busy", 32'(busy), 32'(0));
`ifdef VITCTRL_STATS_EN
        chk("final_frames_done", 32'(frames_done), 32'(m_frames));
        chk("final_underruns", 32'(underruns), 32'(m_under));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
